// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - valid/ready pipeline stage with freeze, flush and optional skid buffer
// Optional statistics outputs (stall_cnt, flush_cnt) are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_hs #(
  parameter int                WIDTH     = 16,
  parameter logic [WIDTH-1:0]  NOP_VALUE = {WIDTH{1'b0}},
  parameter int                SKID      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [7:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_valid;
  logic [1:0]       r_occ;
  logic [1:0]       w_occ_nxt;
  logic             w_space;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;

  // The skid form only looks at the registered full flag, so in_ready has no
  // combinational path from out_ready; the single-register form allows pass-through.
  assign w_space    = (SKID != 0) ? (r_state != ST_TWO) : (~r_valid | out_ready);
  assign w_in_ready = w_space & ~freeze & ~flush & rst;
  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r_valid & out_ready & ~freeze & rst;

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;

  // Next-state and next-data selection; flush outranks freeze, which outranks normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = NOP_VALUE;
      w_skid_nxt  = NOP_VALUE;
    end else if (!freeze) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            // Only reachable with a skid register; without one, in_fire in ONE implies out_fire.
            if (SKID != 0) begin
              w_state_nxt = ST_TWO;
              w_skid_nxt  = in_data;
            end
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = NOP_VALUE;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = NOP_VALUE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = NOP_VALUE;
          w_skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // Occupancy is derived from the next state so the registered count always matches it.
  always_comb begin
    w_occ_nxt = 2'd0;
    case (w_state_nxt)
      ST_ONE:  w_occ_nxt = 2'd1;
      ST_TWO:  w_occ_nxt = 2'd2;
      default: w_occ_nxt = 2'd0;
    endcase
  end

  // State, data and valid registers; reset empties the stage and loads the nop bundle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_main  <= NOP_VALUE;
      r_skid  <= NOP_VALUE;
      r_valid <= 1'b0;
      r_occ   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_occ   <= w_occ_nxt;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [7:0]  r_flush_cnt;

  // Saturating counters of stalled-output cycles and of flushes that discarded live entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 8'd0;
    end else begin
      if (r_valid && (!out_ready || freeze) && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (flush && (r_occ != 2'd0) && (r_flush_cnt != 8'hFF)) begin
        r_flush_cnt <= r_flush_cnt + 8'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - scoreboard bench for pipe_stage_hs (SKID=1/WIDTH=16 and SKID=0/WIDTH=37)
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic        in_valid0, out_ready0;
  logic [36:0] in_data0;
  logic        in_ready0, out_valid0;
  logic [36:0] out_data0;
  logic [1:0]  occupancy0;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt, stall_cnt0;
  logic [7:0]  flush_cnt, flush_cnt0;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];
  logic [36:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(16), .SKID(1)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_hs #(.WIDTH(37), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occupancy0)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h occ=%0d, required 0/0/0000/0",
                 in_ready, out_valid, out_data, occupancy);
      end
      next_cycle();
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b in_ready0=%b, required 1/1", in_ready, in_ready0);
    end
    next_cycle();
  endtask

  task automatic test_streaming();
    logic [15:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      in_data  = 16'(c + 1);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== (c >= 1 && c <= 8)) begin
        errors++;
        $display("FAIL stream_hs c%0d: in_ready=%b out_valid=%b, required 1/%b", c, in_ready, out_valid, (c >= 1 && c <= 8));
      end
      if (out_valid && out_ready && !freeze && rst) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_sb: spurious out_data=%h, none expected", out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL stream_sb: out_data=%h, required %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      next_cycle();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: %0d entries not emitted, required 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    logic        tv[6]  = '{1, 1, 1, 0, 0, 0};
    logic [15:0] td[6]  = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0, 16'h0, 16'h0};
    logic        tr[6]  = '{0, 0, 0, 1, 1, 1};
    logic        er[6]  = '{1, 1, 0, 0, 1, 1};
    logic [1:0]  eo[6]  = '{0, 1, 2, 2, 1, 0};
    logic        eov[6] = '{0, 1, 1, 1, 1, 0};
    logic [15:0] exp;
    for (int c = 0; c < 6; c++) begin
      in_valid = tv[c]; in_data = td[c]; out_ready = tr[c];
      @(negedge clk);
      checks++;
      if (in_ready !== er[c] || occupancy !== eo[c] || out_valid !== eov[c]) begin
        errors++;
        $display("FAIL bp_state c%0d: in_ready=%b occ=%0d out_valid=%b, required %b/%0d/%b",
                 c, in_ready, occupancy, out_valid, er[c], eo[c], eov[c]);
      end
      if (out_valid && out_ready && !freeze && rst) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_sb: spurious out_data=%h, none expected", out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL bp_sb: out_data=%h, required %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      next_cycle();
    end
  endtask

  task automatic test_freeze();
    logic [15:0] exp;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    next_cycle();
    q.delete();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    @(negedge clk);
    if (in_valid && in_ready) q.push_back(in_data);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      freeze = (c < 3); in_valid = (c < 3); in_data = 16'h9999; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || occupancy !== 2'd1 || in_ready !== (c == 3)) begin
        errors++;
        $display("FAIL freeze_hold c%0d: out_valid=%b out_data=%h occ=%0d in_ready=%b, required 1/1234/1/%b",
                 c, out_valid, out_data, occupancy, in_ready, (c == 3));
      end
`ifdef PIPE_STAGE_STATS_EN
      if (c == 3) begin
        checks++;
        if (stall_cnt !== 16'd3) begin
          errors++;
          $display("FAIL freeze_stall_cnt: stall_cnt=%0d, required 3", stall_cnt);
        end
      end
`endif
      if (out_valid && out_ready && !freeze && rst) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL freeze_sb: spurious out_data=%h, none expected", out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL freeze_sb: out_data=%h, required %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      next_cycle();
    end
    freeze = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic        tv[6]  = '{1, 1, 1, 1, 0, 0};
    logic [15:0] td[6]  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0, 16'h0};
    logic        tr[6]  = '{0, 0, 0, 0, 1, 1};
    logic        tf[6]  = '{0, 0, 1, 0, 1, 0};
    logic        er[6]  = '{1, 1, 0, 1, 0, 1};
    logic [1:0]  eo[6]  = '{0, 1, 2, 0, 1, 0};
    logic        eov[6] = '{0, 1, 1, 0, 1, 0};
    logic [15:0] exp;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    next_cycle();
    q.delete();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = tv[c]; in_data = td[c]; out_ready = tr[c]; flush = tf[c];
      @(negedge clk);
      checks++;
      if (in_ready !== er[c] || occupancy !== eo[c] || out_valid !== eov[c] ||
          (!eov[c] && out_data !== 16'h0)) begin
        errors++;
        $display("FAIL flush_state c%0d: in_ready=%b occ=%0d out_valid=%b out_data=%h, required %b/%0d/%b",
                 c, in_ready, occupancy, out_valid, out_data, er[c], eo[c], eov[c]);
      end
`ifdef PIPE_STAGE_STATS_EN
      if (c == 3 || c == 5) begin
        checks++;
        if (flush_cnt !== ((c == 3) ? 8'd1 : 8'd2)) begin
          errors++;
          $display("FAIL flush_cnt c%0d: flush_cnt=%0d, required %0d", c, flush_cnt, (c == 3) ? 1 : 2);
        end
      end
`endif
      if (out_valid && out_ready && !freeze && rst) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL flush_sb: spurious out_data=%h, none expected", out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL flush_sb: out_data=%h, required %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      if (flush) q.delete();
      next_cycle();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic        tv[6]  = '{1, 1, 1, 0, 0, 0};
    logic [15:0] td[6]  = '{16'h0101, 16'h0202, 16'h0303, 16'h0, 16'h0, 16'h0};
    logic        tr[6]  = '{0, 0, 1, 1, 1, 1};
    logic        trs[6] = '{1, 1, 0, 1, 1, 1};
    logic [1:0]  eo[6]  = '{0, 1, 2, 0, 0, 0};
    logic [15:0] exp;
    for (int c = 0; c < 6; c++) begin
      in_valid = tv[c]; in_data = td[c]; out_ready = tr[c]; rst = trs[c];
      @(negedge clk);
      checks++;
      if (occupancy !== eo[c] || (c >= 3 && (out_valid !== 1'b0 || out_data !== 16'h0)) ||
          (c == 2 && in_ready !== 1'b0)) begin
        errors++;
        $display("FAIL reset_mid c%0d: occ=%0d out_valid=%b out_data=%h in_ready=%b, required occ %0d",
                 c, occupancy, out_valid, out_data, in_ready, eo[c]);
      end
      if (out_valid && out_ready && !freeze && rst) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL reset_mid_sb: stale out_data=%h emitted, none expected", out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL reset_mid_sb: out_data=%h, required %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      if (!rst) q.delete();
      next_cycle();
    end
    rst = 1'b1;
  endtask

  task automatic test_skid0();
    logic        bv[5]  = '{1, 1, 1, 0, 0};
    logic [7:0]  bd[5]  = '{8'hA1, 8'hB2, 8'hB2, 8'h00, 8'h00};
    logic        br[5]  = '{0, 0, 1, 1, 1};
    logic        er[5]  = '{1, 0, 1, 1, 1};
    logic [1:0]  eo[5]  = '{0, 1, 1, 1, 0};
    logic [36:0] exp;
    in_valid = 1'b0; out_ready0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid0 = (c < 8);
      in_data0  = {5'h15, 16'hBEEF, 16'(c + 1)};
      @(negedge clk);
      checks++;
      if (in_ready0 !== 1'b1 || out_valid0 !== (c >= 1 && c <= 8)) begin
        errors++;
        $display("FAIL skid0_hs c%0d: in_ready=%b out_valid=%b, required 1/%b", c, in_ready0, out_valid0, (c >= 1 && c <= 8));
      end
      if (out_valid0 && out_ready0 && !freeze && rst) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL skid0_sb: spurious out_data=%h, none expected", out_data0);
        end else begin
          exp = q0.pop_front();
          if (out_data0 !== exp) begin
            errors++;
            $display("FAIL skid0_sb: out_data=%h, required %h", out_data0, exp);
          end
        end
      end
      if (in_valid0 && in_ready0) q0.push_back(in_data0);
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      in_valid0 = bv[c]; in_data0 = {29'h0ABCDEF1, bd[c]}; out_ready0 = br[c];
      @(negedge clk);
      checks++;
      if (in_ready0 !== er[c] || occupancy0 !== eo[c]) begin
        errors++;
        $display("FAIL skid0_bp c%0d: in_ready=%b occ=%0d, required %b/%0d", c, in_ready0, occupancy0, er[c], eo[c]);
      end
      if (out_valid0 && out_ready0 && !freeze && rst) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL skid0_bp_sb: spurious out_data=%h, none expected", out_data0);
        end else begin
          exp = q0.pop_front();
          if (out_data0 !== exp) begin
            errors++;
            $display("FAIL skid0_bp_sb: out_data=%h, required %h", out_data0, exp);
          end
        end
      end
      if (in_valid0 && in_ready0) q0.push_back(in_data0);
      next_cycle();
    end
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL skid0_drain: %0d entries not emitted, required 0", q0.size());
    end
    in_valid0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_freeze();
    test_flush();
    test_reset_mid();
    test_skid0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
